simon_autoplayer: RTL
=====================

Name: simon_autoplayer

Overview:
- Responder side of the Simon playback interface: watches the colour/LED-enable stream the game FSM drives during Simon's turn and records the sequence.
- On request, replays the recorded sequence as emulated active-low button presses, in the same format as the physical simon_btns_n pins.
- Sits beside the game top. Its button outputs are ANDed into simon_btns_n before the debouncers; used for attract/demo mode and hardware self-test.

Parameters:
- MAX_LEN, 32, sequence buffer depth in entries.
- PRESS_CYCLES, 12500000, clocks each emulated button is held (0.25 s at 50 MHz).
- GAP_CYCLES, 12500000, clocks all buttons are released between presses.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  autoplay permitted; low forces idle.
- seq_clear  in  1  one-cycle pulse; empty the buffer (start of a Simon round).
- capture_en  in  1  high while the game is in Simon's display state.
- obs_color  in  2  colour the game is displaying.
- obs_led_en  in  1  game LED enable.
- play_start  in  1  one-cycle pulse; begin replay.
- abort  in  1  one-cycle pulse; stop replay.
- btn_n  out  4  emulated buttons, active-low, one-hot low when pressing.
- busy  out  1  replay in progress.
- done  out  1  one-cycle pulse when replay completes or is skipped.
- seq_len  out  6  entries recorded (clog2(MAX_LEN)+1 bits).
- overflow  out  1  sticky; capture attempted while the buffer was full.

Behaviour:
- Reset values: btn_n=4'b1111, busy=0, done=0, seq_len=0, overflow=0, FSM in IDLE, all pointers 0.
- Capture:
  - obs_led_en is registered. A capture event is a rising edge of obs_led_en while capture_en=1 and the FSM is in IDLE.
  - On an event, obs_color sampled in the same cycle as the edge is written to buf[seq_len], and seq_len increments on the next clock.
  - When seq_len==MAX_LEN, the write is dropped and overflow is set. overflow clears only on seq_clear or reset.
  - seq_clear sets seq_len=0 and overflow=0. If seq_clear and a capture event coincide, the clear applies first and the event is written at index 0, giving seq_len=1.
  - Capture events are ignored while busy.
- Replay FSM, states IDLE, PRESS, GAP, DONE:
  - IDLE: on play_start with enable=1:
    - if seq_len==0, go to DONE;
    - otherwise set rd_ptr=0, load timer=PRESS_CYCLES-1 and go to PRESS.
    - play_start with enable=0 is ignored.
  - PRESS: btn_n[buf[rd_ptr]]=0 and all other bits are 1. The timer counts down; at 0, load GAP_CYCLES-1 and go to GAP. The first press appears on btn_n one clock after the play_start edge.
  - GAP: btn_n=4'b1111. At timer 0, increment rd_ptr:
    - if rd_ptr+1==seq_len, go to DONE;
    - otherwise load PRESS_CYCLES-1 and go to PRESS.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - busy=1 in PRESS and GAP only.
- Abort rules:
  - abort, enable=0 or seq_clear in PRESS or GAP: go to IDLE on the next clock with btn_n=1111 and no done pulse.
  - abort has priority over play_start in the same cycle.
  - play_start while busy is ignored.
- Timing: a full replay of N entries takes N*(PRESS_CYCLES+GAP_CYCLES)+1 clocks from play_start to the done pulse.
- Reset mid-operation: all outputs return to their reset values immediately, asynchronously. Buffer contents need not be cleared.

Optional Feature:
- Macro: SIMON_AUTOPLAY_ERR_INJECT_EN.
- When defined:
  - adds input port inject_err (1 bit), sampled on play_start;
  - if it was 1, the final press of that replay uses colour (buf[last]+1) mod 4, to exercise the game's defeat path.
- When undefined: the port is absent and every replay is faithful to the recorded sequence.

Decomposition:
- Shared package simon_pkg holds:
  - colour constants GREEN=0, RED=1, COLOR2=2, COLOR3=3, and the 2-bit colour typedef;
  - the replay state encoding;
  - the default 50 MHz timing constants (one_sec, quart_sec).
- Sub-module simon_seq_buf: MAX_LEN x 2-bit register file with one synchronous write port, one combinational read port and the length/overflow logic.
- FSM, timer and one-hot-low button decode remain in simon_autoplayer.

Test Plan:
- Sim parameters for all scenarios: PRESS_CYCLES=4, GAP_CYCLES=2.
- Capture: seq_clear, then 3 LED pulses with colours 2,0,3 under capture_en=1 -> seq_len=3, overflow=0. A pulse with capture_en=0 is not recorded.
- Replay: play_start -> btn_n=1011 for 4 clk, then 1111 for 2, then 1110 for 4, then 1111 for 2, then 0111 for 4, then 1111 for 2 -> done pulse at clock 19. busy is low after done.
- Empty replay: seq_clear, then play_start -> done pulses one clock later, busy stays 0, btn_n stays 1111.
- Overflow: with MAX_LEN=4, 6 capture pulses -> seq_len=4, overflow=1. seq_clear -> 0 and 0.
- Abort: abort in the second PRESS -> btn_n=1111 next clock, busy=0, no done. A following play_start restarts from entry 0.
- Async reset: reset_n low in the middle of a PRESS -> btn_n=1111 and busy=0 before the next clock edge. With the macro defined, inject_err=1 makes colour 3 replay as 0 on the final press.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game and its autoplayer.
// Holds the colour type and constants, the replay FSM state encoding,
// the 50 MHz timing constants and the colour-to-button decode helper.
package simon_pkg;

  typedef logic [1:0] color_t;

  localparam color_t GREEN  = 2'd0;
  localparam color_t RED    = 2'd1;
  localparam color_t COLOR2 = 2'd2;
  localparam color_t COLOR3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } replay_state_t;

  localparam int unsigned ONE_SEC   = 50_000_000;
  localparam int unsigned QUART_SEC = ONE_SEC / 4;

  // One-hot-low button pattern for a colour, matching the simon_btns_n pins.
  function automatic logic [3:0] color_to_btn_n(input color_t c);
    return ~(4'b0001 << c);
  endfunction

endpackage

// File: rtl/simon_autoplayer_if.sv
// Control/observation bundle between the game top (master) and the
// autoplayer (slave).
// master drives: enable, seq_clear, capture_en, obs_color, obs_led_en,
//                play_start, abort (and inject_err when
//                SIMON_AUTOPLAY_ERR_INJECT_EN is defined)
// slave drives:  btn_n, busy, done, seq_len, overflow
interface simon_autoplayer_if;
  import simon_pkg::*;

  logic         enable;
  logic         seq_clear;
  logic         capture_en;
  color_t       obs_color;
  logic         obs_led_en;
  logic         play_start;
  logic         abort;
  logic [3:0]   btn_n;
  logic         busy;
  logic         done;
  logic [5:0]   seq_len;
  logic         overflow;
`ifdef SIMON_AUTOPLAY_ERR_INJECT_EN
  logic         inject_err;

  modport master (
    output enable, seq_clear, capture_en, obs_color, obs_led_en,
           play_start, abort, inject_err,
    input  btn_n, busy, done, seq_len, overflow
  );

  modport slave (
    input  enable, seq_clear, capture_en, obs_color, obs_led_en,
           play_start, abort, inject_err,
    output btn_n, busy, done, seq_len, overflow
  );
`else
  modport master (
    output enable, seq_clear, capture_en, obs_color, obs_led_en,
           play_start, abort,
    input  btn_n, busy, done, seq_len, overflow
  );

  modport slave (
    input  enable, seq_clear, capture_en, obs_color, obs_led_en,
           play_start, abort,
    output btn_n, busy, done, seq_len, overflow
  );
`endif

endinterface

// File: rtl/simon_seq_buf.sv
// Sequence buffer: MAX_LEN x 2-bit register file, one synchronous write
// port appending at the current length, one combinational read port, plus
// the length counter and sticky overflow flag.
// Ports: clk, reset_n (async active-low), i_clear (empty buffer),
//        i_wr_en/i_wr_data (append), i_rd_addr/o_rd_data (read),
//        o_len (entries stored), o_overflow (append attempted when full).
module simon_seq_buf
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_clear,
  input  logic                       i_wr_en,
  input  color_t                     i_wr_data,
  input  logic [$clog2(MAX_LEN)-1:0] i_rd_addr,
  output color_t                     o_rd_data,
  output logic [$clog2(MAX_LEN):0]   o_len,
  output logic                       o_overflow
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN);
  localparam int unsigned LEN_W = IDX_W + 1;

  color_t           r_mem [MAX_LEN];
  logic [LEN_W-1:0] r_len;
  logic             r_overflow;

  logic [LEN_W-1:0] w_len_base;
  logic             w_full;
  logic             w_wr;

  // A clear in the same cycle as a write empties first, so the write lands at 0.
  assign w_len_base = i_clear ? '0 : r_len;
  assign w_full     = (w_len_base == LEN_W'(MAX_LEN));
  assign w_wr       = i_wr_en && !w_full;

  // Storage is left unreset; only the length decides what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_len_base[IDX_W-1:0]] <= i_wr_data;
  end

  // Length and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_len      <= w_wr ? (w_len_base + LEN_W'(1)) : w_len_base;
      r_overflow <= (r_overflow && !i_clear) || (i_wr_en && w_full);
    end
  end

  assign o_rd_data  = r_mem[i_rd_addr];
  assign o_len      = r_len;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/simon_autoplayer.sv
// Simon autoplayer: records the colour sequence the game shows during
// Simon's turn and replays it as emulated active-low button presses.
// Ports: clk, reset_n (async active-low), bus (simon_autoplayer_if.slave).
// Optional: define SIMON_AUTOPLAY_ERR_INJECT_EN to add bus.inject_err;
// when sampled high on play_start, the final press of that replay is the
// next colour (mod 4) instead of the recorded one.
module simon_autoplayer
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 32,
  parameter int unsigned PRESS_CYCLES = QUART_SEC,
  parameter int unsigned GAP_CYCLES   = QUART_SEC
) (
  input logic                clk,
  input logic                reset_n,
  simon_autoplayer_if.slave  bus
);

  localparam int unsigned IDX_W   = $clog2(MAX_LEN);
  localparam int unsigned LEN_W   = IDX_W + 1;
  localparam int unsigned TMR_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  replay_state_t    r_state, w_state_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [IDX_W-1:0] r_rd_ptr, w_rd_ptr_nxt;
  logic             r_led_prev;
  logic [3:0]       r_btn_n;
  logic             r_busy;
  logic             r_done;

  logic             w_capture;
  logic             w_stop;
  logic             w_last;
  logic [LEN_W-1:0] w_len;
  logic             w_overflow;
  color_t           w_rd_data;
  color_t           w_play_color;

`ifdef SIMON_AUTOPLAY_ERR_INJECT_EN
  logic             r_inject, w_inject_nxt;
  logic             w_last_nxt;
`endif

  // Capture on a rising LED edge seen while the game shows Simon's turn.
  assign w_capture = bus.obs_led_en && !r_led_prev && bus.capture_en && (r_state == ST_IDLE);
  assign w_stop    = bus.abort || !bus.enable || bus.seq_clear;
  assign w_last    = ((LEN_W'(r_rd_ptr) + LEN_W'(1)) == w_len);

  simon_seq_buf #(.MAX_LEN(MAX_LEN)) u_seq_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (bus.seq_clear),
    .i_wr_en    (w_capture),
    .i_wr_data  (bus.obs_color),
    .i_rd_addr  (w_rd_ptr_nxt),
    .o_rd_data  (w_rd_data),
    .o_len      (w_len),
    .o_overflow (w_overflow)
  );

  // State, timer and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_rd_ptr   <= '0;
      r_led_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_led_prev <= bus.obs_led_en;
    end
  end

  // Replay next-state logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_rd_ptr_nxt = r_rd_ptr;
`ifdef SIMON_AUTOPLAY_ERR_INJECT_EN
    w_inject_nxt = r_inject;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (bus.play_start && bus.enable && !bus.abort) begin
          if (w_len == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt  = ST_PRESS;
            w_rd_ptr_nxt = '0;
            w_timer_nxt  = TMR_W'(PRESS_CYCLES - 1);
`ifdef SIMON_AUTOPLAY_ERR_INJECT_EN
            w_inject_nxt = bus.inject_err;
`endif
          end
        end
      end
      ST_PRESS: begin
        if (w_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (r_timer == '0) begin
          w_state_nxt = ST_GAP;
          w_timer_nxt = TMR_W'(GAP_CYCLES - 1);
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (w_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (r_timer == '0) begin
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt  = ST_PRESS;
            w_rd_ptr_nxt = r_rd_ptr + IDX_W'(1);
            w_timer_nxt  = TMR_W'(PRESS_CYCLES - 1);
          end
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef SIMON_AUTOPLAY_ERR_INJECT_EN
  // Corrupt only the final press of a replay flagged for error injection.
  assign w_last_nxt   = ((LEN_W'(w_rd_ptr_nxt) + LEN_W'(1)) == w_len);
  assign w_play_color = (w_inject_nxt && w_last_nxt) ? color_t'(w_rd_data + 2'd1) : w_rd_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_inject <= 1'b0;
    else          r_inject <= w_inject_nxt;
  end
`else
  assign w_play_color = w_rd_data;
`endif

  // Outputs are registered from the next state so they track it without lag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_n <= 4'b1111;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_btn_n <= (w_state_nxt == ST_PRESS) ? color_to_btn_n(w_play_color) : 4'b1111;
      r_busy  <= (w_state_nxt == ST_PRESS) || (w_state_nxt == ST_GAP);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  assign bus.btn_n    = r_btn_n;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.seq_len  = 6'(w_len);
  assign bus.overflow = w_overflow;

endmodule
